fifo_rdstream: RTL and testbench

FIFO_RDSTREAM -- requirements
Module: fifo_rdstream

---
 rtl/fifo_rdstream_if.sv | 28 ++
 rtl/fifo_rdstream.sv | 112 +++++++++++
 tb/tb_fifo_rdstream.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rdstream_if.sv
// Handshake bundle between fifo_rdstream, its FIFO controller/memory and the
// downstream consumer. The master side is the streaming block itself.
interface fifo_rdstream_if #(
   parameter int unsigned DW   = 8,
   parameter int unsigned ADDR = 4
);
   logic            notempty;
   logic [ADDR:0]   fifolen;
   logic            fiford;
   logic            fifoflsh;
   logic [DW-1:0]   mem_rdat;
   logic            out_vld;
   logic [DW-1:0]   out_dat;
   logic            out_rdy;
   logic            flush_req;
   logic            flush_done;
   logic [ADDR+1:0] avail;

   modport master (
      input  notempty, fifolen, mem_rdat, out_rdy, flush_req,
      output fiford, fifoflsh, out_vld, out_dat, flush_done, avail
   );

   modport slave (
      output notempty, fifolen, mem_rdat, out_rdy, flush_req,
      input  fiford, fifoflsh, out_vld, out_dat, flush_done, avail
   );
endinterface

// File: rtl/fifo_rdstream.sv
// Turns a FIFO controller + 1-cycle-latency memory into a valid/ready stream
// through a 2-entry skid buffer, with a drain/flush sequence on request.
module fifo_rdstream #(
   parameter int unsigned DW   = 8,
   parameter int unsigned ADDR = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   fifo_rdstream_if.master bus
);
   localparam int unsigned CW = 2;
   localparam int unsigned OW = 3;
   localparam int unsigned AW = ADDR + 2;

   typedef enum logic [1:0] {RUN, DRAIN, FLSH, DONE} state_e;

   state_e        state_q, state_d;
   logic [DW-1:0] slot_q [2];
   logic          rd_ptr_q, rd_ptr_d;
   logic          wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          inflt_q, inflt_d;

   logic          out_vld_c;
   logic          xfer_c;
   logic          fiford_c;
   logic          fifoflsh_c;
   logic          flush_done_c;
   logic [OW-1:0] occ_nx_c;

   // FSM: next state and strobes
   always_comb begin
      state_d      = state_q;
      fiford_c     = 1'b0;
      fifoflsh_c   = 1'b0;
      flush_done_c = 1'b0;
      out_vld_c    = (state_q == RUN) && (cnt_q != '0);
      xfer_c       = out_vld_c && bus.out_rdy;
      // occupancy after this edge if no new read is launched
      occ_nx_c     = OW'(cnt_q) + OW'(inflt_q) - OW'(xfer_c);
      unique case (state_q)
         RUN: begin
            fiford_c = bus.notempty && (occ_nx_c < OW'(2));
            if (bus.flush_req) state_d = DRAIN;
         end
         DRAIN: begin
            // no read is launched here, so any in-flight word lands on this edge
            state_d = FLSH;
         end
         FLSH: begin
            fifoflsh_c = 1'b1;
            state_d    = DONE;
         end
         DONE: begin
            flush_done_c = 1'b1;
            state_d      = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RUN;
      else        state_q <= state_d;
   end

   // Buffer bookkeeping
   always_comb begin
      inflt_d  = fiford_c;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q + CW'(inflt_q) - CW'(xfer_c);
      if (inflt_q) wr_ptr_d = ~wr_ptr_q;
      if (xfer_c)  rd_ptr_d = ~rd_ptr_q;
      if (state_q == FLSH) begin
         cnt_d    = '0;
         wr_ptr_d = rd_ptr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         inflt_q   <= 1'b0;
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         slot_q[0] <= '0;
         slot_q[1] <= '0;
      end else begin
         cnt_q    <= cnt_d;
         inflt_q  <= inflt_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         if (inflt_q) slot_q[wr_ptr_q] <= bus.mem_rdat;
      end
   end

   assign bus.fiford     = fiford_c;
   assign bus.fifoflsh   = fifoflsh_c;
   assign bus.flush_done = flush_done_c;
   assign bus.out_vld    = out_vld_c;
   assign bus.out_dat    = slot_q[rd_ptr_q];
   assign bus.avail      = AW'(bus.fifolen) + AW'(cnt_q) + AW'(inflt_q);

`ifndef SYNTHESIS
   a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
      (OW'(cnt_q) + OW'(inflt_q)) <= OW'(2));
   a_flsh_pulse: assert property (@(posedge clk) disable iff (!rst_n)
      fifoflsh_c |=> !fifoflsh_c);
`endif

endmodule

// File: tb/tb_fifo_rdstream.sv
// Scoreboard bench for fifo_rdstream: a FIFO controller/memory model feeds the
// DUT, expected words are queued at stimulus time and checked by a monitor.
module tb_fifo_rdstream;
   localparam int unsigned DW   = 8;
   localparam int unsigned ADDR = 4;
   localparam int unsigned LW   = ADDR + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   fifo_rdstream_if #(.DW(DW), .ADDR(ADDR)) bus ();

   fifo_rdstream #(.DW(DW), .ADDR(ADDR)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] fifo [$];
   logic [DW-1:0] exp_q [$];

   int n_chk = 0;
   int n_err = 0;
   int cyc_n = 0;
   int fr_cnt, first_fr, first_vld, xfer_cnt, vld_cnt;
   int flsh_cnt, flsh_cyc, done_cnt, done_cyc;

   task automatic chk(input string nm, input int act, input int want);
      n_chk++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc_n);
      end
   endtask

   task automatic upd();
      bus.notempty = (fifo.size() != 0);
      bus.fifolen  = LW'(fifo.size());
   endtask

   task automatic push_word(input logic [DW-1:0] w, input bit keep);
      fifo.push_back(w);
      if (keep) exp_q.push_back(w);
      upd();
   endtask

   task automatic clr();
      fr_cnt = 0; first_fr = -1; first_vld = -1; xfer_cnt = 0; vld_cnt = 0;
      flsh_cnt = 0; flsh_cyc = -1; done_cnt = 0; done_cyc = -1;
   endtask

   // one clock: sample at negedge, then model the FIFO controller after the edge
   task automatic cyc();
      logic fr, fl;
      @(negedge clk);
      fr = bus.fiford;
      fl = bus.fifoflsh;
      if (fr) begin
         fr_cnt++;
         if (first_fr < 0) first_fr = cyc_n;
      end
      if (fl) begin flsh_cnt++; flsh_cyc = cyc_n; end
      if (bus.flush_done) begin done_cnt++; done_cyc = cyc_n; end
      if (bus.out_vld) vld_cnt++;
      @(posedge clk);
      #1;
      cyc_n++;
      if (fl) fifo.delete();
      else if (fr) begin
         chk("fiford_on_nonempty", int'(fifo.size() != 0), 1);
         if (fifo.size() != 0) bus.mem_rdat = fifo.pop_front();
      end
      upd();
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst_n && bus.out_vld) begin
         if (first_vld < 0) first_vld = cyc_n;
         if (bus.out_rdy) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL xfer_unexpected: got %0h expected none", bus.out_dat);
            end else begin
               chk("xfer_data", int'(bus.out_dat), int'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      int start;
      bus.notempty  = 1'b0;
      bus.fifolen   = '0;
      bus.mem_rdat  = '0;
      bus.out_rdy   = 1'b0;
      bus.flush_req = 1'b0;
      clr();
      #2 rst_n = 1'b0;
      #10;
      chk("rst_fiford",     int'(bus.fiford), 0);
      chk("rst_fifoflsh",   int'(bus.fifoflsh), 0);
      chk("rst_out_vld",    int'(bus.out_vld), 0);
      chk("rst_out_dat",    int'(bus.out_dat), 0);
      chk("rst_flush_done", int'(bus.flush_done), 0);
      chk("rst_avail",      int'(bus.avail), 0);
      #1 rst_n = 1'b1;
      run(2);

      // streaming
      clr();
      bus.out_rdy = 1'b1;
      push_word(8'h11, 1); push_word(8'h22, 1); push_word(8'h33, 1);
      run(8);
      chk("stream_first_vld_lat", first_vld - first_fr, 2);
      chk("stream_xfers", xfer_cnt, 3);
      chk("stream_fifords", fr_cnt, 3);
      chk("stream_vld_cycles", vld_cnt, 3);
      chk("stream_avail_end", int'(bus.avail), 0);

      // backpressure
      clr();
      bus.out_rdy = 1'b0;
      push_word(8'hA1, 1); push_word(8'hA2, 1); push_word(8'hA3, 1);
      push_word(8'hA4, 1); push_word(8'hA5, 1);
      run(6);
      chk("bp_fifords", fr_cnt, 2);
      chk("bp_fiford_now", int'(bus.fiford), 0);
      chk("bp_out_vld", int'(bus.out_vld), 1);
      chk("bp_out_dat", int'(bus.out_dat), 'hA1);
      chk("bp_avail", int'(bus.avail), 5);
      run(1);
      chk("bp_out_dat_hold", int'(bus.out_dat), 'hA1);
      bus.out_rdy = 1'b1;
      run(8);
      chk("bp_drain_xfers", xfer_cnt, 5);
      chk("bp_drain_avail", int'(bus.avail), 0);

      // flush with a read in flight
      clr();
      bus.out_rdy = 1'b0;
      push_word(8'hB1, 0); push_word(8'hB2, 0); push_word(8'hB3, 0);
      bus.flush_req = 1'b1;
      start = cyc_n;
      cyc();
      bus.flush_req = 1'b0;
      run(5);
      chk("fl_fifords", fr_cnt, 1);
      chk("fl_flsh_cycle", flsh_cyc - start, 2);
      chk("fl_flsh_pulses", flsh_cnt, 1);
      chk("fl_done_after_flsh", done_cyc - flsh_cyc, 1);
      chk("fl_done_pulses", done_cnt, 1);
      chk("fl_vld_cycles", vld_cnt, 0);
      chk("fl_avail_after", int'(bus.avail), 0);
      clr();
      bus.out_rdy = 1'b1;
      push_word(8'hC1, 1);
      run(5);
      chk("fl_post_xfers", xfer_cnt, 1);

      // empty boundary
      clr();
      run(5);
      chk("empty_fifords", fr_cnt, 0);
      chk("empty_vld_cycles", vld_cnt, 0);
      push_word(8'hD1, 1);
      run(6);
      chk("single_fifords", fr_cnt, 1);
      chk("single_xfers", xfer_cnt, 1);

      // landing write and transfer in the same cycle
      clr();
      bus.out_rdy = 1'b0;
      push_word(8'hE1, 1);
      run(4);
      chk("sim_pre_vld", int'(bus.out_vld), 1);
      chk("sim_pre_avail", int'(bus.avail), 1);
      push_word(8'hE2, 1);
      cyc();
      bus.out_rdy = 1'b1;
      cyc();
      bus.out_rdy = 1'b0;
      chk("sim_xfers", xfer_cnt, 1);
      chk("sim_out_vld", int'(bus.out_vld), 1);
      chk("sim_out_dat", int'(bus.out_dat), 'hE2);
      chk("sim_avail", int'(bus.avail), 1);
      bus.out_rdy = 1'b1;
      run(3);
      chk("sim_exp_empty", exp_q.size(), 0);

      // asynchronous reset mid-stream
      clr();
      push_word(8'hF1, 1); push_word(8'hF2, 1); push_word(8'hF3, 1);
      push_word(8'hF4, 1); push_word(8'hF5, 1); push_word(8'hF6, 1);
      run(4);
      chk("ar_pre_xfers", xfer_cnt, 2);
      #2 rst_n = 1'b0;
      fifo.delete();
      exp_q.delete();
      upd();
      #1;
      chk("ar_fiford",     int'(bus.fiford), 0);
      chk("ar_out_vld",    int'(bus.out_vld), 0);
      chk("ar_out_dat",    int'(bus.out_dat), 0);
      chk("ar_fifoflsh",   int'(bus.fifoflsh), 0);
      chk("ar_flush_done", int'(bus.flush_done), 0);
      chk("ar_avail",      int'(bus.avail), 0);
      run(2);
      rst_n = 1'b1;
      clr();
      push_word(8'h5A, 1); push_word(8'h6B, 1); push_word(8'h7C, 1);
      run(8);
      chk("ar_restart_xfers", xfer_cnt, 3);
      chk("ar_restart_lat", first_vld - first_fr, 2);
      chk("ar_restart_flsh", flsh_cnt + done_cnt, 0);

      chk("final_exp_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
